// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the uart tx path
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // 10 bit times at the slowest baud of the 115200 build, plus margin
  localparam int TX_TIMEOUT_DEFAULT = 262144;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first set bit after ptr
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit after ptr wins
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart transmitter among byte requesters
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = TX_TIMEOUT_DEFAULT,
  localparam int ID_W           = $clog2(N_REQ),
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_REQ-1:0]   reqValid,
  input  logic [8*N_REQ-1:0] reqData,
  output logic [N_REQ-1:0]   reqReady,
  output logic               txEnable,
  output logic               txStart,
  output logic [7:0]         txData,
  input  logic               txBusy,
  input  logic               txDone,
  output logic [ID_W-1:0]    grantId,
  output logic               busy,
  output logic               timeoutErr
);

  tx_state_t        state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             grant;
  logic             waiting;
  logic             timeout_hit;
  logic [7:0]       pick_byte;
  logic [CNT_W-1:0] count_q;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (reqValid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // rst_n gates the accept so no ack can leak out while the block is held in reset
  assign grant       = rst_n && (state_q == ST_IDLE) && enable && !txBusy && pick_any;
  assign waiting     = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  // a txDone landing on the last allowed cycle still counts as a clean finish
  assign timeout_hit = waiting && !txDone && (count_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeoutErr  = timeout_hit;
  assign busy        = (state_q != ST_IDLE);

  // Winner's byte and one-hot accept pulse
  always_comb begin
    pick_byte = '0;
    reqReady  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_byte   = reqData[8*i +: 8];
        reqReady[i] = grant;
      end
    end
  end

  // Next-state logic for the transmit sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (txDone)           state_d = ST_IDLE;
        else if (timeout_hit) state_d = ST_IDLE;
        else if (txBusy)      state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (txDone || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Grant bookkeeping, registered byte and transmitter strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= ID_W'(N_REQ - 1);
      grantId  <= '0;
      txData   <= '0;
      txStart  <= 1'b0;
      txEnable <= 1'b0;
    end else begin
      txStart  <= grant;
      txEnable <= enable || (state_d != ST_IDLE);
      if (grant) begin
        rr_ptr_q <= pick_idx;
        grantId  <= pick_idx;
        txData   <= pick_byte;
      end
    end
  end

  // Timeout counter: cleared on the start strobe, runs while waiting on the transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (state_q == ST_START) begin
      count_q <= '0;
    end else if (waiting && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        txEnable;
  logic        txStart;
  logic [7:0]  txData;
  logic        txBusy;
  logic        txDone;
  logic [1:0]  grantId;
  logic        busy;
  logic        timeoutErr;

  int total = 0;
  int bad   = 0;
  int mon_bad = 0;
  int tx_mode = 0;   // 0 busy+done, 1 done only, 2 silent
  int tx_dur  = 4;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .txEnable   (txEnable),
    .txStart    (txStart),
    .txData     (txData),
    .txBusy     (txBusy),
    .txDone     (txDone),
    .grantId    (grantId),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural transmitter
  initial begin
    int m;
    int d;
    txBusy = 1'b0;
    txDone = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && txStart) begin
        m = tx_mode;
        d = tx_dur;
        if (m != 2) begin
          @(posedge clk); #1;
          if (m == 0) txBusy = 1'b1;
          for (int k = 0; k < d && rst_n; k++) begin
            @(posedge clk); #1;
          end
          txBusy = 1'b0;
          if (rst_n) begin
            txDone = 1'b1;
            @(posedge clk); #1;
            txDone = 1'b0;
          end
        end
      end
    end
  end

  // Ack invariants watched over the whole run
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(reqReady) > 1) mon_bad++;
      if (reqReady != 4'b0 && busy) mon_bad++;
      if (txStart && !busy) mon_bad++;
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    reqValid = 4'b0;
    tx_mode  = 0;
    tx_dur   = 4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    reqValid = 4'b1111;
    reqData  = 32'h12345678;
    @(negedge clk);
    total++; if (reqReady !== 4'b0)  begin bad++; $display("FAIL reset_ready: got %b want 0000", reqReady); end
    total++; if (txStart !== 1'b0)   begin bad++; $display("FAIL reset_start: got %b want 0", txStart); end
    total++; if (txData !== 8'h00)   begin bad++; $display("FAIL reset_data: got %h want 00", txData); end
    total++; if (txEnable !== 1'b0)  begin bad++; $display("FAIL reset_txen: got %b want 0", txEnable); end
    total++; if (grantId !== 2'd0)   begin bad++; $display("FAIL reset_grant: got %0d want 0", grantId); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (timeoutErr !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeoutErr); end
    do_reset();
  endtask

  task automatic test_single();
    logic seen;
    enable = 1'b1;
    tx_mode = 0;
    tx_dur  = 5;
    @(posedge clk); #1;
    reqData  = 32'h008F0000;
    reqValid = 4'b0100;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    total++; if (!seen || reqReady !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", reqReady); end
    total++; if (txStart !== 1'b0) begin bad++; $display("FAIL single_start_early: got %b want 0", txStart); end
    @(posedge clk); #1 reqValid = 4'b0;
    @(negedge clk);
    total++; if (txStart !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", txStart); end
    total++; if (txData !== 8'h8F) begin bad++; $display("FAIL single_data: got %h want 8f", txData); end
    total++; if (grantId !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grantId); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (txDone) seen = 1'b1;
    end
    total++; if (!seen || busy !== 1'b1) begin bad++; $display("FAIL single_done: seen %b busy %b want 1 1", seen, busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic seen;
    logic [3:0] want;
    do_reset();
    enable   = 1'b1;
    tx_dur   = 3;
    reqData  = 32'hA3A2A1A0;
    reqValid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      want = 4'b0001 << (g % 4);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        if (reqReady != 4'b0) seen = 1'b1;
      end
      total++; if (!seen || reqReady !== want) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", g, reqReady, want); end
      @(negedge clk);
      total++; if (txStart !== 1'b1 || txData !== 8'hA0 + 8'(g % 4)) begin
        bad++; $display("FAIL rr_byte[%0d]: start %b data %h want 1 %h", g, txStart, txData, 8'hA0 + 8'(g % 4));
      end
    end
    reqValid = 4'b0;
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
  endtask

  task automatic test_enable();
    logic seen;
    logic quiet;
    logic en_ok;
    do_reset();
    tx_dur = 6;
    @(posedge clk); #1;
    reqData  = 32'h44332211;
    reqValid = 4'b1111;
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (reqReady !== 4'b0 || txStart !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL en_off_grant: got activity want none"); end
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    total++; if (!seen || reqReady !== 4'b0001) begin bad++; $display("FAIL en_on_grant: got %b want 0001", reqReady); end
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    total++; if (txStart !== 1'b1 || txData !== 8'h11) begin bad++; $display("FAIL en_start: start %b data %h want 1 11", txStart, txData); end
    seen = 1'b0;
    en_ok = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy && txEnable !== 1'b1) en_ok = 1'b0;
      if (txDone) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL en_midbyte_done: got no txDone want txDone"); end
    total++; if (!en_ok) begin bad++; $display("FAIL en_txen_held: got txEnable 0 while busy want 1"); end
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (reqReady !== 4'b0 || txStart !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL en_after_drop: got grant want none"); end
    total++; if (txEnable !== 1'b0) begin bad++; $display("FAIL en_txen_low: got %b want 0", txEnable); end
    reqValid = 4'b0;
  endtask

  task automatic test_timeout();
    logic seen;
    int n;
    do_reset();
    enable  = 1'b1;
    tx_mode = 2;
    @(posedge clk); #1;
    reqData  = 32'h00005A00;
    reqValid = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    total++; if (!seen || reqReady !== 4'b0010) begin bad++; $display("FAIL to_grant: got %b want 0010", reqReady); end
    @(posedge clk); #1 reqValid = 4'b0;
    @(negedge clk);
    total++; if (txStart !== 1'b1) begin bad++; $display("FAIL to_start: got %b want 1", txStart); end
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (timeoutErr) break;
    end
    total++; if (n !== 101) begin bad++; $display("FAIL to_latency: got %0d want 101", n); end
    @(negedge clk);
    total++; if (timeoutErr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse: err %b busy %b want 0 0", timeoutErr, busy); end
    tx_mode = 0;
    @(posedge clk); #1 reqValid = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    total++; if (!seen || reqReady !== 4'b1000) begin bad++; $display("FAIL to_next_grant: got %b want 1000", reqReady); end
    @(posedge clk); #1 reqValid = 4'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    enable = 1'b1;
    tx_dur = 30;
    @(posedge clk); #1;
    reqData  = 32'h00C30077;
    reqValid = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    @(posedge clk); #1 reqValid = 4'b0101;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1 || txBusy !== 1'b1) begin bad++; $display("FAIL rm_inflight: busy %b txBusy %b want 1 1", busy, txBusy); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (reqReady !== 4'b0 || txStart !== 1'b0 || timeoutErr !== 1'b0) begin
      bad++; $display("FAIL rm_strobes: ready %b start %b err %b want 0", reqReady, txStart, timeoutErr);
    end
    total++; if (txData !== 8'h00 || grantId !== 2'd0) begin bad++; $display("FAIL rm_regs: data %h grant %0d want 00 0", txData, grantId); end
    total++; if (busy !== 1'b0 || txEnable !== 1'b0) begin bad++; $display("FAIL rm_busy: busy %b txen %b want 0 0", busy, txEnable); end
    tx_dur = 4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    total++; if (!seen || reqReady !== 4'b0001) begin bad++; $display("FAIL rm_first_after: got %b want 0001", reqReady); end
    @(posedge clk); #1 reqValid = 4'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
  endtask

  task automatic test_done_coincident();
    logic seen;
    logic held;
    enable = 1'b1;
    tx_mode = 0;
    tx_dur  = 6;
    @(posedge clk); #1;
    reqData  = 32'hEE0000DD;
    reqValid = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (reqReady != 4'b0) seen = 1'b1;
    end
    @(posedge clk); #1 reqValid = 4'b1000;
    seen = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (reqReady !== 4'b0) held = 1'b0;
      if (txDone) seen = 1'b1;
    end
    total++; if (!seen || !held) begin bad++; $display("FAIL dc_done_cycle: seen %b ready-quiet %b want 1 1", seen, held); end
    @(negedge clk);
    total++; if (reqReady !== 4'b1000) begin bad++; $display("FAIL dc_next_grant: got %b want 1000", reqReady); end
    @(posedge clk); #1 reqValid = 4'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] valid;
    logic [3:0] acked;
    logic [7:0] bytes [4];
    logic [7:0] exp_byte;
    logic       exp_pending;
    int         last;
    int         want;
    int         grants;
    do_reset();
    enable = 1'b1;
    valid = '0;
    acked = '0;
    exp_pending = 1'b0;
    exp_byte = '0;
    last = 3;
    grants = 0;
    for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (acked[i]) begin
          valid[i] = 1'b0;
          acked[i] = 1'b0;
        end else if (!valid[i] && $urandom_range(0, 7) == 0) begin
          valid[i] = 1'b1;
          bytes[i] = 8'($urandom);
        end else if (valid[i] && $urandom_range(0, 63) == 0) begin
          valid[i] = 1'b0;
        end
        reqData[8*i +: 8] = bytes[i];
      end
      reqValid = valid;
      @(negedge clk);
      if (exp_pending) begin
        total++; if (txStart !== 1'b1 || txData !== exp_byte) begin
          bad++; $display("FAIL rand_byte: start %b data %h want 1 %h", txStart, txData, exp_byte);
        end
        exp_pending = 1'b0;
      end
      if (reqReady != 4'b0) begin
        want = -1;
        for (int k = 4; k >= 1; k--) if (valid[(last + k) % 4]) want = (last + k) % 4;
        total++; if (want < 0 || reqReady !== (4'b0001 << want)) begin
          bad++; $display("FAIL rand_winner: got %b want index %0d", reqReady, want);
        end
        if (want >= 0) begin
          last = want;
          acked[want] = 1'b1;
          exp_byte = bytes[want];
          exp_pending = 1'b1;
        end
        grants++;
        tx_mode = int'($urandom_range(0, 1));
        tx_dur  = int'($urandom_range(1, 12));
      end
    end
    total++; if (grants < 20) begin bad++; $display("FAIL rand_progress: got %0d grants want >=20", grants); end
    reqValid = 4'b0;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    tx_mode = 0;
  endtask

  task automatic test_invariants();
    total++; if (mon_bad != 0) begin bad++; $display("FAIL ack_invariants: got %0d violations want 0", mon_bad); end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    reqValid = 4'b0;
    reqData  = 32'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_enable();
    test_timeout();
    test_reset_mid();
    test_done_coincident();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N byte requesters.
- Accepts bytes over a per-requester valid/ready handshake and registers the winning byte.
- Sequences the transmitter via txStart/txBusy/txDone and supervises each byte with a timeout.
- Sits between client logic (command/status sources) and the tx half of uart_top.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of grant index (derived localparam).
- TIMEOUT_CYCLES, 262144, max clocks from txStart to txDone before abort (covers 10 bits at slowest baud plus margin).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived localparam).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable; low blocks new grants only.
- reqValid  in  N_REQ  per-requester byte valid.
- reqData  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- reqReady  out  N_REQ  one-cycle accept pulse, one-hot.
- txEnable  out  1  transmitter enable to uart tx.
- txStart  out  1  start strobe to uart tx.
- txData  out  8  byte to uart tx (drives `in`).
- txBusy  in  1  transmitter busy.
- txDone  in  1  transmitter done pulse (one clk).
- grantId  out  ID_W  index of the current/last owner.
- busy  out  1  high whenever state is not IDLE.
- timeoutErr  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces the following values:
  - state=IDLE, reqReady=0, txStart=0, txData=0, txEnable=0, grantId=0, busy=0, timeoutErr=0, rrPtr=N_REQ-1, counter=0.
- txEnable is registered and equals `enable` one clock later. An in-flight byte still completes after enable falls, because txEnable is held high while busy=1.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grants when enable=1, txBusy=0 and any reqValid is set.
  - Winner is the first set bit searching from rrPtr+1 upward, wrapping modulo N_REQ.
  - Same cycle: reqReady[winner]=1, reqData slice registered into txData, grantId=winner, rrPtr=winner, go to START.
  - Requesters must hold reqData stable while reqValid=1 until reqReady.
- START: txStart=1 for exactly one clock, counter cleared, go to WAIT_BUSY.
- WAIT_BUSY:
  - txBusy=1 goes to WAIT_DONE.
  - If txDone is seen first (fast tx), go directly to IDLE.
- WAIT_DONE: txDone=1 goes to IDLE. A txDone pulse arriving while in IDLE/START is ignored.
- Timeout:
  - Counter increments each clock in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: timeoutErr pulses 1 clk, return to IDLE, no retry. The byte is dropped; it was already acked.
- Minimum spacing: grant-to-grant is at least 3 clocks plus tx duration. No grant occurs in the cycle txDone is seen; the earliest next reqReady is the following clock.
- Fairness: the requester just served has lowest priority next round. A single active requester may be granted back-to-back.
- enable falling mid-byte: current byte finishes normally, then the block stays in IDLE.
- Reset mid-byte: outputs return to reset values immediately. txStart can never be glitched high by reset.
- reqValid deasserted before grant: no ack and no state change (requesters may withdraw).
- Only one reqReady bit is ever high. reqReady is never high outside IDLE.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE=2'd0, START=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the default timeout constant for the 115200-baud build.
- Sub-module rr_pick: combinational round-robin selector (inputs req[N_REQ], ptr[ID_W]; outputs any, idx[ID_W]), reusable by a later rx dispatcher.
- FSM, data register and timeout counter stay in uart_tx_arbiter.

Test Plan (N_REQ=4, clk period 20 ns, behavioural tx model driving txBusy/txDone):
- Single request: reqValid=4'b0100, byte 8'h8F -> reqReady[2] pulse, txStart pulse next clk with txData=8'h8F, grantId=2, busy falls 1 clk after txDone.
- All four valid continuously, bytes 8'hA0..8'hA3 -> transmit order 0,1,2,3,0,... with no requester served twice before the others.
- enable=0 while requests are pending -> no reqReady, txStart stays 0. Drop enable mid-byte -> that byte's txDone still occurs, then no further grant.
- Tx model never raises txBusy/txDone, TIMEOUT_CYCLES=100 -> timeoutErr pulses exactly 101 clks after txStart, state IDLE, next request granted.
- rst_n pulsed low during WAIT_DONE -> all outputs at reset values within the same clock. After release, pending request granted to requester 0 first (rrPtr=3).
- txDone coincident with a new reqValid -> reqReady delayed one clock, never asserted in the txDone cycle.
